pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an external PWM waveform and

---
 rtl/pwm_capture_pkg.sv | 16 +
 rtl/pwm_div_restoring.sv | 65 ++++++
 rtl/pwm_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Constants shared by the PWM capture block and its divider: result width,
// divide length and the FSM encodings also used by the PWM generator.
package pwm_capture_pkg;

  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned DIV_STEPS = 8;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_ARMED   = 2'd1;
  localparam logic [ST_W-1:0] ST_MEASURE = 2'd2;

  localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

endpackage

// File: rtl/pwm_div_restoring.sv
// 8-step restoring divider: q = floor(num * 256 / den), valid only for num < den.
// done_c/q_c flag the final iteration so the caller can register the result directly.
module pwm_div_restoring
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic [DUTY_W-1:0] q_c,
  output logic              done_c,
  output logic              busy
);

  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_den;
  logic [DUTY_W-2:0] r_q;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;

  logic [CNT_W:0]    w_shift;
  logic              w_ge;
  logic [CNT_W-1:0]  w_rem_nxt;

  // rem < den is invariant, so the restored remainder always fits CNT_W bits
  always_comb begin
    w_shift   = {r_rem, 1'b0};
    w_ge      = (w_shift >= {1'b0, r_den});
    w_rem_nxt = w_ge ? (w_shift[CNT_W-1:0] - r_den) : w_shift[CNT_W-1:0];
    q_c       = {r_q, w_ge};
    done_c    = r_busy && (r_step == STEP_W'(DIV_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start && !r_busy) begin
      r_rem  <= num;
      r_den  <= den;
      r_q    <= '0;
      r_step <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_q    <= q_c[DUTY_W-2:0];
      r_step <= r_step + STEP_W'(1);
      if (done_c) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/pwm_capture.sv
// Measures an external PWM waveform: period and high time in clk cycles between
// successive rising edges, then duty = floor(high*256/period) via a sequential divider.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] dutyCycle,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT_CYCLES);

  logic r_sync1, r_sync2, r_level, r_rise, r_fall;
  logic [ST_W-1:0]   r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_per_cnt, r_high_cnt, r_idle_cnt, r_per_lat;
  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W-1:0]  r_period;
  logic              r_valid, r_timeout, r_overrun;

  logic              w_to_hit, w_measuring, w_take, w_drop, w_abort;
  logic [DUTY_W-1:0] w_q;
  logic              w_done, w_busy;

  // Synchroniser plus registered edge pulses; r_level is the level aligned with them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_level <= r_sync2;
      r_rise  <= r_sync2 & ~r_level;
      r_fall  <= ~r_sync2 & r_level;
    end
  end

  always_comb begin
    w_to_hit    = enable & ~r_rise & ~r_fall & (r_idle_cnt == TO_LAST);
    w_measuring = (r_state != ST_IDLE);
    w_take      = enable & r_rise & w_measuring & ~w_busy;
    w_drop      = enable & r_rise & w_measuring & w_busy;
    w_abort     = ~enable | w_to_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // First rise only arms; every later rise closes a period
  always_comb begin
    w_state_nxt = r_state;
    if (!enable || w_to_hit) begin
      w_state_nxt = ST_IDLE;
    end else if (r_rise) begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ARMED;
        ST_ARMED:   w_state_nxt = ST_MEASURE;
        ST_MEASURE: w_state_nxt = ST_MEASURE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
      r_idle_cnt <= '0;
      r_per_lat  <= '0;
    end else if (!enable) begin
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (r_rise) begin
        r_per_cnt  <= CNT_W'(1);
        r_high_cnt <= CNT_W'(1);
      end else begin
        if (r_per_cnt != CNT_MAX)              r_per_cnt  <= r_per_cnt + CNT_W'(1);
        if (r_level && r_high_cnt != CNT_MAX)  r_high_cnt <= r_high_cnt + CNT_W'(1);
      end
      if (r_rise || r_fall)          r_idle_cnt <= '0;
      else if (r_idle_cnt != TO_FULL) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      if (w_take) r_per_lat <= r_per_cnt;
    end
  end

  pwm_div_restoring #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (w_take),
    .abort  (w_abort),
    .num    (r_high_cnt),
    .den    (r_per_cnt),
    .q_c    (w_q),
    .done_c (w_done),
    .busy   (w_busy)
  );

  // A static input overrides a divide finishing in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty    <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      if (!enable) begin
        r_timeout <= 1'b0;
      end else if (w_to_hit) begin
        r_duty    <= r_level ? DUTY_FULL : '0;
        r_period  <= '0;
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
      end else begin
        if (w_done) begin
          r_duty   <= w_q;
          r_period <= r_per_lat;
          r_valid  <= 1'b1;
        end
        if (r_rise) r_timeout <= 1'b0;
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

  assign dutyCycle = r_duty;
  assign period    = r_period;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus random PWM segments,
// every cycle compared against an event-level reference model built from the pin history.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 24;
  localparam int          TO    = 1000;
  localparam int          LAT   = 3;
  localparam int          MAXC  = 65536;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             pwm_in;
  logic [7:0]       dutyCycle;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;
  logic             overrun;

  pwm_capture #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .dutyCycle (dutyCycle),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int duty;
    int per;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   vcount, ocount;
  bit   ph [0:MAXC-1];
  res_t pend[$];
  int   armed, last_rise, free_at, idle;
  int   e_duty, e_per;
  bit   e_valid, e_over, e_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit pin_at(input int i);
    return (i < 0) ? 1'b0 : ph[i];
  endfunction

  function automatic int high_between(input int a, input int b);
    int s = 0;
    for (int i = a; i < b; i++) s += int'(pin_at(i));
    return s;
  endfunction

  task automatic model_reset();
    pend.delete();
    armed = 0; last_rise = 0; free_at = 0; idle = 0;
    e_duty = 0; e_per = 0; e_valid = 0; e_over = 0; e_to = 0;
  endtask

  // Expected outputs after the next clock edge, from the pin as seen LAT cycles later
  task automatic model_step();
    bit lvl, rise, fall;
    int k, p, h;
    k = cyc;
    e_valid = 0;
    e_over  = 0;
    lvl  = pin_at(k - LAT);
    rise = lvl && !pin_at(k - LAT - 1);
    fall = !lvl && pin_at(k - LAT - 1);
    if (!enable) begin
      armed = 0; pend.delete(); idle = 0; e_to = 0; free_at = 0;
      return;
    end
    if (pend.size() > 0 && pend[0].due == k + 1) begin
      e_duty  = pend[0].duty;
      e_per   = pend[0].per;
      e_valid = 1;
      void'(pend.pop_front());
    end
    if (rise) begin
      if (armed != 0) begin
        p = k - last_rise;
        h = high_between(last_rise - LAT, k - LAT);
        if (k >= free_at) begin
          pend.push_back(res_t'{due: k + 9, duty: (h * 256) / p, per: p});
          free_at = k + 9;
        end else begin
          e_over = 1;
        end
      end
      armed = 1; last_rise = k; idle = 0; e_to = 0;
    end else if (fall) begin
      idle = 0;
    end else if (idle == TO - 1) begin
      e_duty = lvl ? 255 : 0; e_per = 0; e_valid = 1; e_to = 1;
      armed = 0; pend.delete(); free_at = 0; idle = TO;
    end else if (idle < TO) begin
      idle++;
    end
  endtask

  task automatic tick();
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    ph[cyc] = pwm_in;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("valid",   32'(valid),     32'(e_valid));
    chk("overrun", 32'(overrun),   32'(e_over));
    chk("timeout", 32'(timeout),   32'(e_to));
    chk("duty",    32'(dutyCycle), 32'(e_duty));
    chk("period",  32'(period),    32'(e_per));
    vcount += int'(valid);
    ocount += int'(overrun);
  endtask

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    repeat (n) tick();
  endtask

  task automatic periods(input int per, input int hi, input int n);
    repeat (n) begin
      drive(1'b1, hi);
      drive(1'b0, per - hi);
    end
  endtask

  task automatic en_pulse();
    enable = 1'b0;
    drive(1'b0, 4);
    enable = 1'b1;
  endtask

  initial begin
    bit hit;
    int per, hi;
    rst = 1'b0; enable = 1'b0; pwm_in = 1'b0;
    cyc = 0; vcount = 0; ocount = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty",   32'(dutyCycle), 32'd0);
    chk("rst_period", 32'(period),    32'd0);
    chk("rst_valid",  32'(valid),     32'd0);
    chk("rst_to",     32'(timeout),   32'd0);
    chk("rst_ovr",    32'(overrun),   32'd0);
    rst = 1'b1;
    enable = 1'b1;
    drive(1'b0, 5);

    // period 256 / high 64, four rising edges
    vcount = 0; ocount = 0;
    periods(256, 64, 4);
    drive(1'b0, 10);
    chk("t1_valids", 32'(vcount),    32'd3);
    chk("t1_duty",   32'(dutyCycle), 32'd64);
    chk("t1_period", 32'(period),    32'd256);

    // period 1000 / high 333
    en_pulse();
    vcount = 0; ocount = 0;
    periods(1000, 333, 4);
    drive(1'b0, 10);
    chk("t2_duty",    32'(dutyCycle), 32'd85);
    chk("t2_period",  32'(period),    32'd1000);
    chk("t2_overrun", 32'(ocount),    32'd0);
    chk("t2_timeout", 32'(timeout),   32'd0);

    // static low, static high, then a fresh rising edge
    en_pulse();
    vcount = 0;
    drive(1'b0, 1010);
    chk("t3_low_duty",   32'(dutyCycle), 32'd0);
    chk("t3_low_to",     32'(timeout),   32'd1);
    chk("t3_low_valids", 32'(vcount),    32'd1);
    vcount = 0;
    drive(1'b1, 1010);
    chk("t3_high_duty",   32'(dutyCycle), 32'd255);
    chk("t3_high_to",     32'(timeout),   32'd1);
    chk("t3_high_valids", 32'(vcount),    32'd1);
    drive(1'b0, 10);
    vcount = 0;
    drive(1'b1, 10);
    chk("t3_clear_to",     32'(timeout), 32'd0);
    chk("t3_clear_valids", 32'(vcount),  32'd0);

    // period 6 / high 3: divider still busy on the next edge
    en_pulse();
    vcount = 0; ocount = 0;
    periods(6, 3, 8);
    drive(1'b0, 20);
    chk("t4_duty",         32'(dutyCycle),        32'd128);
    chk("t4_overrun_seen", 32'(ocount != 0),      32'd1);
    chk("t4_valid_seen",   32'(vcount != 0),      32'd1);

    // asynchronous reset four cycles into a divide
    en_pulse();
    periods(256, 64, 2);
    hit = 1'b0;
    for (int i = 0; i < 256 && !hit; i++) begin
      pwm_in = (i < 64);
      tick();
      hit = (pend.size() > 0) && (pend[0].due - cyc == 5);
    end
    chk("t5_reach_e4", 32'(hit), 32'd1);
    rst = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("t5_rst_duty",   32'(dutyCycle), 32'd0);
    chk("t5_rst_period", 32'(period),    32'd0);
    chk("t5_rst_valid",  32'(valid),     32'd0);
    chk("t5_rst_to",     32'(timeout),   32'd0);
    model_reset();
    for (int i = cyc - 4; i <= cyc; i++) if (i >= 0) ph[i] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      cyc++;
      ph[cyc] = 1'b0;
    end
    rst = 1'b1;
    vcount = 0;
    drive(1'b0, 6);
    periods(256, 64, 3);
    drive(1'b0, 10);
    chk("t5_valids", 32'(vcount),    32'd2);
    chk("t5_duty",   32'(dutyCycle), 32'd64);

    // enable dropped mid-period: result held, restart needs two edges
    en_pulse();
    periods(200, 50, 3);
    drive(1'b1, 30);
    enable = 1'b0;
    drive(1'b1, 20);
    drive(1'b0, 20);
    chk("t6_held_duty", 32'(dutyCycle), 32'd64);
    chk("t6_held_per",  32'(period),    32'd200);
    enable = 1'b1;
    vcount = 0;
    periods(200, 50, 1);
    chk("t6_no_valid", 32'(vcount), 32'd0);
    periods(200, 50, 2);
    chk("t6_valids", 32'(vcount), 32'd2);

    // random segments, occasionally restarted or interrupted
    for (int s = 0; s < 10; s++) begin
      per = int'($urandom_range(4, 300));
      hi  = int'($urandom_range(1, per - 1));
      if ($urandom_range(0, 2) == 0) en_pulse();
      periods(per, hi, int'($urandom_range(2, 5)));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        drive(1'b1, int'($urandom_range(1, 6)));
        enable = 1'b1;
      end
      drive(1'b0, int'($urandom_range(3, 15)));
    end
    drive(1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
